// File: rtl/waitstate_ctrl_pkg.sv
// rtl/waitstate_ctrl_pkg.sv - shared region/wait-state definitions
// Purpose: GBA memory region enum, FSM state enum, MEM_SIZE encodings and
//          the WAITCNT N/S decode constants shared by the wait-state logic.
// Ports:   none (package).
package waitstate_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [3:0] {
    REG_BIOS,
    REG_EWRAM,
    REG_IWRAM,
    REG_IO,
    REG_PAL,
    REG_VRAM,
    REG_OAM,
    REG_WS0,
    REG_WS1,
    REG_WS2,
    REG_SRAM,
    REG_UNMAPPED
  } region_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Sequential-access wait when the WAITCNT S bit is set, and the slow
  // per-window value used when it is clear.
  localparam logic [4:0] S_FAST     = 5'd1;
  localparam logic [4:0] S_WS0_SLOW = 5'd2;
  localparam logic [4:0] S_WS1_SLOW = 5'd4;
  localparam logic [4:0] S_WS2_SLOW = 5'd8;

  // Non-sequential (and SRAM) wait for a 2-bit WAITCNT code.
  function automatic logic [4:0] n_code_wait(input logic [1:0] code);
    case (code)
      2'd0:    n_code_wait = 5'd4;
      2'd1:    n_code_wait = 5'd3;
      2'd2:    n_code_wait = 5'd2;
      default: n_code_wait = 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/waitstate_ctrl_region_decode.sv
// rtl/waitstate_ctrl_region_decode.sv - region decode and wait-count calculation
// Purpose: combinational decode of a CPU access into a memory region and the
//          number of wait cycles it costs.
// Ports:   i_addr    CPU address
//          i_size    MEM_SIZE_* access size
//          i_waitcnt WAITCNT register value
//          i_seq     access is classed sequential
//          o_region  decoded region
//          o_wait    wait cycles for this access
module ws_region_decode
  import waitstate_ctrl_pkg::*;
#(
  parameter int EWRAM_WAIT     = 2,
  parameter int VRAM_WORD_WAIT = 1,
  parameter int CNT_W          = 5
) (
  input  logic [31:0]      i_addr,
  input  logic [1:0]       i_size,
  input  logic [15:0]      i_waitcnt,
  input  logic             i_seq,
  output region_e          o_region,
  output logic [CNT_W-1:0] o_wait
);

  logic             w_is_word;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_s;
  logic             w_unused;

  assign w_is_word = (i_size == MEM_SIZE_WORD);
  assign w_unused  = ^{i_addr[23:0], i_waitcnt[15:11]};

  always_comb begin
    o_region = REG_UNMAPPED;
    if (i_addr[31:28] == 4'h0) begin
      case (i_addr[27:24])
        4'h0:        o_region = REG_BIOS;
        4'h2:        o_region = REG_EWRAM;
        4'h3:        o_region = REG_IWRAM;
        4'h4:        o_region = REG_IO;
        4'h5:        o_region = REG_PAL;
        4'h6:        o_region = REG_VRAM;
        4'h7:        o_region = REG_OAM;
        4'h8, 4'h9:  o_region = REG_WS0;
        4'hA, 4'hB:  o_region = REG_WS1;
        4'hC, 4'hD:  o_region = REG_WS2;
        4'hE, 4'hF:  o_region = REG_SRAM;
        default:     o_region = REG_UNMAPPED;
      endcase
    end
  end

  always_comb begin
    w_n    = '0;
    w_s    = '0;
    o_wait = '0;
    case (o_region)
      REG_WS0: begin
        w_n = CNT_W'(n_code_wait(i_waitcnt[3:2]));
        w_s = CNT_W'(i_waitcnt[4] ? S_FAST : S_WS0_SLOW);
      end
      REG_WS1: begin
        w_n = CNT_W'(n_code_wait(i_waitcnt[6:5]));
        w_s = CNT_W'(i_waitcnt[7] ? S_FAST : S_WS1_SLOW);
      end
      REG_WS2: begin
        w_n = CNT_W'(n_code_wait(i_waitcnt[9:8]));
        w_s = CNT_W'(i_waitcnt[10] ? S_FAST : S_WS2_SLOW);
      end
      default: begin
        w_n = '0;
        w_s = '0;
      end
    endcase

    case (o_region)
      // A ROM word is two 16-bit bus transfers; the second is always S.
      REG_WS0, REG_WS1, REG_WS2:
        o_wait = (i_seq ? w_s : w_n) + (w_is_word ? (w_s + CNT_W'(1)) : '0);
      REG_EWRAM:
        o_wait = w_is_word ? CNT_W'(2 * EWRAM_WAIT + 1) : CNT_W'(EWRAM_WAIT);
      REG_PAL, REG_VRAM:
        o_wait = w_is_word ? CNT_W'(VRAM_WORD_WAIT) : '0;
      REG_SRAM:
        o_wait = CNT_W'(n_code_wait(i_waitcnt[1:0]));
      default:
        o_wait = '0;
    endcase
  end

endmodule

// File: rtl/waitstate_ctrl.sv
// rtl/waitstate_ctrl.sv - GBA bus wait-state controller
// Purpose: accepts a CPU access on every idle cycle, classes GamePak accesses
//          as sequential or not, stalls the core for the decoded wait count
//          and flags illegal writes. Optional macro WAITSTATE_STATS_EN adds
//          stall and ROM non-sequential counters.
// Ports:   i_clk, i_rst       clock, synchronous active-high reset
//          i_addr, i_size     CPU address and MEM_SIZE_* size
//          i_write            CPU write strobe
//          i_waitcnt          WAITCNT register value
//          o_pause            stall to core and memories
//          o_abort            one-cycle illegal-access flag
//          o_seq              last accepted access was sequential
//          o_stall_cycles     (stats) saturating count of paused cycles
//          o_rom_n_count      (stats) non-sequential ROM accesses
module waitstate_ctrl
  import waitstate_ctrl_pkg::*;
#(
  parameter int EWRAM_WAIT     = 2,
  parameter int VRAM_WORD_WAIT = 1,
  parameter int CNT_W          = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_write,
  input  logic [15:0] i_waitcnt,
`ifdef WAITSTATE_STATS_EN
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_rom_n_count,
`endif
  output logic        o_pause,
  output logic        o_abort,
  output logic        o_seq
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_prev_addr;
  logic [1:0]       r_prev_size;
  region_e          r_prev_region;
  logic             r_prev_valid;
  logic             r_pause;
  logic             r_abort;
  logic             r_seq;

  region_e          w_region;
  logic [CNT_W-1:0] w_wait;
  logic             w_accept;
  logic             w_is_ws;
  logic             w_seq_now;
  logic             w_abort_now;
  logic [31:0]      w_next_addr;

  ws_region_decode #(
    .EWRAM_WAIT     (EWRAM_WAIT),
    .VRAM_WORD_WAIT (VRAM_WORD_WAIT),
    .CNT_W          (CNT_W)
  ) u_decode (
    .i_addr    (i_addr),
    .i_size    (i_size),
    .i_waitcnt (i_waitcnt),
    .i_seq     (w_seq_now),
    .o_region  (w_region),
    .o_wait    (w_wait)
  );

  assign w_accept    = (r_state == ST_IDLE);
  assign w_is_ws     = (w_region == REG_WS0) || (w_region == REG_WS1) ||
                       (w_region == REG_WS2);
  assign w_next_addr = r_prev_addr + ((r_prev_size == MEM_SIZE_WORD) ? 32'd4 : 32'd2);
  // Region decode does not depend on seq, so feeding seq back into the
  // decoder forms no combinational loop. A 128 KiB boundary restarts the
  // ROM burst and forces a non-sequential access.
  assign w_seq_now   = r_prev_valid && w_is_ws && (w_region == r_prev_region) &&
                       (i_addr == w_next_addr) && (i_addr[16:0] != 17'd0);
  // BIOS plus the upper half of the 0-1 window (addr[31:25]==0) and ROM are read-only.
  assign w_abort_now = i_write && ((i_addr[31:25] == 7'd0) || w_is_ws);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_wait != '0) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = w_wait;
        end
      end
      ST_WAIT: begin
        // <=1 rather than ==1 so a corrupted zero count can never wrap.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_prev_addr   <= '0;
      r_prev_size   <= MEM_SIZE_BYTE;
      r_prev_region <= REG_UNMAPPED;
      r_prev_valid  <= 1'b0;
      r_pause       <= 1'b0;
      r_abort       <= 1'b0;
      r_seq         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pause <= (w_state_nxt == ST_WAIT);
      r_abort <= w_accept && w_abort_now;
      if (w_accept) begin
        r_prev_addr   <= i_addr;
        r_prev_size   <= i_size;
        r_prev_region <= w_region;
        r_prev_valid  <= 1'b1;
        r_seq         <= w_seq_now;
      end
    end
  end

`ifdef WAITSTATE_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_rom_n_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_rom_n_count  <= '0;
    end else begin
      if (r_pause && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_accept && w_is_ws && !w_seq_now)
        r_rom_n_count <= r_rom_n_count + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_rom_n_count  = r_rom_n_count;
`endif

  assign o_pause = r_pause;
  assign o_abort = r_abort;
  assign o_seq   = r_seq;

endmodule
